sample_stream_pacer: RTL and testbench

- Transmit-side producer of the gapped sample stream that the downstream gap-filling/interpolation stage consumes.
- Accepts 16-bit signed samples from an upstream source over ready/valid and buffers them in a small FIFO.
- Emits exactly one output slot per sample tick:
  - valid_out=1 with a sample when one is available;
  - valid_out=0 (a gap) on underflow.
- Tracks consecutive gaps and declares stream loss when too many occur, then re-primes.

---
 rtl/sample_stream_pacer_pkg.sv | 11 +
 rtl/sample_stream_pacer_fifo.sv | 54 +++++
 rtl/sample_stream_pacer.sv | 151 +++++++++++++++
 tb/tb_sample_stream_pacer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sample_stream_pacer_pkg.sv
// Shared types and widths for the sample pacer and the downstream gap-filling stage.
package sample_stream_pacer_pkg;
  localparam int SAMPLE_W = 16;
  localparam int GAP_W    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } pacer_state_e;
endpackage

// File: rtl/sample_stream_pacer_fifo.sv
// Synchronous FIFO with occupancy counter and flush; full/empty derive from the count.
module sample_stream_pacer_fifo
  import sample_stream_pacer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = SAMPLE_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       wr_en_i,
  input  logic [W-1:0]               wr_data_i,
  input  logic                       rd_en_i,
  output logic [W-1:0]               rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_wr, do_rd;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign do_wr     = wr_en_i && !full_o;
  assign do_rd     = rd_en_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_wr) - CW'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end
endmodule

// File: rtl/sample_stream_pacer.sv
// Paces buffered samples out one slot per tick, marking gaps on underflow and re-priming on loss.
// Optional PACER_GAP_STATS_EN adds saturating gap_total / lost_events counters.
module sample_stream_pacer
  import sample_stream_pacer_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int TICK_DIV    = 4,
  parameter int MAX_GAP     = 7,
  parameter int PRIME_LEVEL = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_in_valid,
  output logic                       sample_in_ready,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       valid_out,
  output logic [GAP_W-1:0]           gap_run,
  output logic                       stream_lost,
  output logic [$clog2(DEPTH):0]     fill_level
`ifdef PACER_GAP_STATS_EN
  ,
  output logic [15:0]                gap_total,
  output logic [7:0]                 lost_events
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [CW-1:0]    PRIME_LVL = CW'(PRIME_LEVEL);
  localparam logic [GAP_W-1:0] GAP_MAX   = GAP_W'(MAX_GAP);
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);

  pacer_state_e                state_q, state_d;
  logic [TW-1:0]               tick_q, tick_d;
  logic signed [SAMPLE_W-1:0]  sample_q, sample_d;
  logic                        valid_q, valid_d;
  logic [GAP_W-1:0]            gap_q, gap_d;
  logic                        lost_q, lost_d;
  logic                        tick, pop, flush, full, empty;
  logic [SAMPLE_W-1:0]         head;
  logic [CW-1:0]               count;
`ifdef PACER_GAP_STATS_EN
  logic [15:0] gap_tot_q, gap_tot_d;
  logic [7:0]  lost_ev_q, lost_ev_d;
`endif

  assign tick            = (tick_q == TICK_LAST);
  assign flush           = !enable || (state_q == IDLE);
  assign sample_in_ready = (state_q != IDLE) && !full;

  sample_stream_pacer_fifo #(.DEPTH(DEPTH), .W(SAMPLE_W)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush_i   (flush),
    .wr_en_i   (sample_in_valid && sample_in_ready),
    .wr_data_i (sample_in),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .full_o    (full),
    .empty_o   (empty),
    .count_o   (count)
  );

  always_comb begin
    state_d  = state_q;
    tick_d   = (state_q == IDLE || tick) ? '0 : tick_q + 1'b1;
    sample_d = sample_q;
    valid_d  = 1'b0;
    gap_d    = gap_q;
    lost_d   = lost_q;
    pop      = 1'b0;
`ifdef PACER_GAP_STATS_EN
    gap_tot_d = gap_tot_q;
    lost_ev_d = lost_ev_q;
`endif
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  state_d = PRIME;
        PRIME: if (count >= PRIME_LVL) begin
          lost_d  = 1'b0;
          gap_d   = '0;
          state_d = RUN;
        end
        RUN: if (tick) begin
          if (!empty) begin
            pop      = 1'b1;
            sample_d = head;
            valid_d  = 1'b1;
            gap_d    = '0;
          end else begin
            gap_d = (gap_q == GAP_MAX) ? gap_q : gap_q + 1'b1;
`ifdef PACER_GAP_STATS_EN
            if (gap_tot_q != '1) gap_tot_d = gap_tot_q + 1'b1;
`endif
            // gap_q stays below GAP_MAX in RUN, so this cannot overflow.
            if (gap_q == GAP_MAX - 1'b1) begin
              lost_d  = 1'b1;
              state_d = PRIME;
`ifdef PACER_GAP_STATS_EN
              if (lost_ev_q != '1) lost_ev_d = lost_ev_q + 1'b1;
`endif
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      gap_q    <= '0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      gap_q    <= gap_d;
      lost_q   <= lost_d;
    end
  end

`ifdef PACER_GAP_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_tot_q <= '0;
      lost_ev_q <= '0;
    end else begin
      gap_tot_q <= gap_tot_d;
      lost_ev_q <= lost_ev_d;
    end
  end

  assign gap_total   = gap_tot_q;
  assign lost_events = lost_ev_q;
`endif

  assign sample_out  = sample_q;
  assign valid_out   = valid_q;
  assign gap_run     = gap_q;
  assign stream_lost = lost_q;
  assign fill_level  = count;
endmodule

// File: tb/tb_sample_stream_pacer.sv
// Scoreboard bench for sample_stream_pacer: accepted samples queue up, emitted samples are popped and compared.
module tb_sample_stream_pacer;
  localparam int DEPTH   = 8;
  localparam int MAX_GAP = 7;

  logic clk = 1'b0;
  logic reset, enable, sample_in_valid;
  logic signed [15:0] sample_in;
  logic sample_in_ready, valid_out, stream_lost;
  logic signed [15:0] sample_out;
  logic [2:0] gap_run;
  logic [3:0] fill_level;
`ifdef PACER_GAP_STATS_EN
  logic [15:0] gap_total;
  logic [7:0]  lost_events;
`endif

  int checks = 0, failures = 0, cyc = 0, n_valid = 0;
  logic signed [15:0] exp_q[$];
  logic prev_v = 1'b0;

  always #5 clk = ~clk;

  sample_stream_pacer dut (
    .clk(clk), .reset(reset), .enable(enable),
    .sample_in(sample_in), .sample_in_valid(sample_in_valid), .sample_in_ready(sample_in_ready),
    .sample_out(sample_out), .valid_out(valid_out), .gap_run(gap_run),
    .stream_lost(stream_lost), .fill_level(fill_level)
`ifdef PACER_GAP_STATS_EN
    , .gap_total(gap_total), .lost_events(lost_events)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Accepted writes become expected outputs.
  always @(posedge clk) begin
    cyc++;
    if (!reset && sample_in_valid && sample_in_ready) exp_q.push_back(sample_in);
  end

  always @(negedge clk) begin
    if (valid_out) begin
      n_valid++;
      chk("no_back_to_back", prev_v, 0);
      chk("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("sample_out", sample_out, exp_q.pop_front());
    end
    prev_v = valid_out;
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic signed [15:0] v);
    logic r;
    int t = 0;
    sample_in = v;
    sample_in_valid = 1'b1;
    do begin r = sample_in_ready; step(1); t++; end while (!r && t < 50);
    chk("push_accepted", r, 1);
    sample_in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int c);
    int t = 0;
    do begin step(1); t++; end while (!valid_out && t < 64);
    chk("valid_seen", valid_out, 1);
    c = cyc;
  endtask

  task automatic chk_reset_vals();
    chk("rst_sample_out", sample_out, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_gap_run", gap_run, 0);
    chk("rst_stream_lost", stream_lost, 0);
    chk("rst_fill_level", fill_level, 0);
    chk("rst_ready", sample_in_ready, 0);
`ifdef PACER_GAP_STATS_EN
    chk("rst_gap_total", gap_total, 0);
    chk("rst_lost_events", lost_events, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c, c2, s, nv, t;
    logic saw_full, rdy_at_full;
    reset = 1'b1; enable = 1'b0; sample_in_valid = 1'b0; sample_in = '0;
    step(3);
    chk_reset_vals();

    // Prime with four samples; first emission at the tick after RUN entry.
    reset = 1'b0; enable = 1'b1; c0 = cyc;
    push(100); push(200); push(300); push(400);
    wait_valid(c);
    chk("first_emit_latency", c - c0, 9);
    for (int k = 0; k < 3; k++) begin
      wait_valid(c2);
      chk("emit_spacing", c2 - c, 4);
      c = c2;
    end

    // Underflow gaps hold the last sample.
    push(50);
    wait_valid(s);
    chk("spacing_50", s - c, 4);
    chk("gap_after_50", gap_run, 0);
    step(4);
    chk("gap1_valid", valid_out, 0);
    chk("gap1_hold", sample_out, 50);
    chk("gap1_run", gap_run, 1);
    step(4);
    chk("gap2_valid", valid_out, 0);
    chk("gap2_hold", sample_out, 50);
    chk("gap2_run", gap_run, 2);
    push(60);
    wait_valid(c);
    chk("spacing_60", c - s, 12);
    chk("gap_cleared", gap_run, 0);

    // Starve into stream loss.
    for (int k = 1; k <= MAX_GAP; k++) begin
      step(4);
      chk("loss_valid", valid_out, 0);
      chk("loss_gap_run", gap_run, k);
      chk("loss_flag", stream_lost, k == MAX_GAP);
    end
    push(1); push(2); push(3); push(4);
    chk("lost_while_priming", stream_lost, 1);
    chk("prime_fill", fill_level, 4);
    step(1);
    chk("lost_cleared", stream_lost, 0);
    chk("gap_cleared_run", gap_run, 0);
    for (int k = 0; k < 4; k++) wait_valid(c);

    // Backpressure: continuous input, count 20 emissions.
    nv = n_valid; saw_full = 1'b0; rdy_at_full = 1'b1; t = 0;
    sample_in = 1000; sample_in_valid = 1'b1;
    while (n_valid - nv < 20 && t < 300) begin
      logic r;
      r = sample_in_ready;
      if (fill_level == DEPTH && !saw_full) begin saw_full = 1'b1; rdy_at_full = sample_in_ready; end
      step(1); t++;
      if (r) sample_in++;
    end
    sample_in_valid = 1'b0;
    chk("bp_emitted", n_valid - nv >= 20, 1);
    chk("bp_reached_full", saw_full, 1);
    chk("bp_ready_low_full", rdy_at_full, 0);

    // Enable drop flushes and requires re-prime.
    t = 0;
    while (fill_level != 5 && t < 100) begin step(1); t++; end
    chk("drain_to_5", fill_level, 5);
    enable = 1'b0;
    step(1);
    chk("idle_fill", fill_level, 0);
    chk("idle_ready", sample_in_ready, 0);
    exp_q.delete();
    nv = n_valid;
    step(8);
    chk("idle_no_emit", n_valid - nv, 0);
    enable = 1'b1;
    push(7001); push(7002);
    nv = n_valid;
    step(12);
    chk("reprime_no_emit", n_valid - nv, 0);
    chk("reprime_fill", fill_level, 2);
    push(7003); push(7004);
    wait_valid(c);

    // Reset mid-stream clears everything at once.
    reset = 1'b1;
    #1;
    chk_reset_vals();
    exp_q.delete();
    step(2);
    reset = 1'b0;

    // 3 gaps, refill, then 7 gaps into loss.
    push(11); push(12); push(13); push(14);
    for (int k = 0; k < 4; k++) wait_valid(s);
    for (int k = 1; k <= 3; k++) begin
      step(4);
      chk("st_gap_run", gap_run, k);
    end
    push(15);
    wait_valid(c);
    chk("st_refill_spacing", c - s, 16);
    chk("st_refill_gap", gap_run, 0);
    for (int k = 1; k <= MAX_GAP; k++) begin
      step(4);
      chk("st_loss_gap", gap_run, k);
    end
    chk("st_lost", stream_lost, 1);
`ifdef PACER_GAP_STATS_EN
    chk("gap_total", gap_total, 10);
    chk("lost_events", lost_events, 1);
`endif
    step(20);
    chk("st_gap_saturated", gap_run, MAX_GAP);
    chk("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
